// File: rtl/ps2_mouse_ctrl.sv
// Host-side PS/2 mouse sequencer: runs the reset/enable handshake, then turns
// 3-byte stream packets into a clamped absolute cursor position and button state.
module ps2_mouse_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BAT_CYCLES     = 50000000,
    parameter int RETRY_MAX      = 3,
    parameter int XW             = 10,
    parameter int YW             = 10,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_err,
    output logic          tx_req,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    input  logic          tx_done,
    input  logic          tx_err,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    buttons,
    output logic          pkt_valid,
    output logic          ready,
    output logic          init_fail,
    output logic          sync_err
);

    // state        | meaning
    // SEND_RST     | issue 0xFF once the transmitter is idle, wait for tx_done
    // WAIT_RST_ACK | expect 0xFA
    // WAIT_BAT     | expect self-test result 0xAA (long timeout)
    // WAIT_ID      | expect device id 0x00
    // SEND_EN      | issue 0xF4, wait for tx_done
    // WAIT_EN_ACK  | expect 0xFA
    // RETRY        | bump attempt count, restart or give up
    // FAIL         | terminal until reset
    // STREAM       | assemble movement packets
    localparam logic [3:0] SEND_RST     = 4'd0;
    localparam logic [3:0] WAIT_RST_ACK = 4'd1;
    localparam logic [3:0] WAIT_BAT     = 4'd2;
    localparam logic [3:0] WAIT_ID      = 4'd3;
    localparam logic [3:0] SEND_EN      = 4'd4;
    localparam logic [3:0] WAIT_EN_ACK  = 4'd5;
    localparam logic [3:0] RETRY        = 4'd6;
    localparam logic [3:0] FAIL         = 4'd7;
    localparam logic [3:0] STREAM       = 4'd8;

    localparam int TMO_MAX = (BAT_CYCLES > TIMEOUT_CYCLES) ? BAT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(TMO_MAX + 1);
    localparam int RW      = $clog2(RETRY_MAX + 1);
    localparam int CW      = ((XW > YW) ? XW : YW) + 2;

    localparam logic signed [CW-1:0] X_MAX_S = CW'(X_MAX);
    localparam logic signed [CW-1:0] Y_MAX_S = CW'(Y_MAX);

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic          tx_sent;
    logic          send_go;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_load;
    logic          tmo_zero;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_inc;
    logic          is_wait;
    logic [7:0]    exp_byte;
    logic [3:0]    succ_state;

    // header keeps b0 minus the always-set sync bit: {y_ovf, x_ovf, y_sign, x_sign, btn[2:0]}
    logic [6:0]    hdr;
    logic [7:0]    b1;
    logic [7:0]    b2;
    logic [1:0]    idx;
    logic          upd;

    logic [8:0]           dx;
    logic [8:0]           dy;
    logic signed [CW-1:0] x_sum;
    logic signed [CW-1:0] y_sum;
    logic [XW-1:0]        x_clamp;
    logic [YW-1:0]        y_clamp;

    assign tmo_zero  = (tmo_cnt == '0);
    assign retry_inc = retry_cnt + RW'(1);
    assign send_go   = ((state == SEND_RST) || (state == SEND_EN)) && !tx_sent && !tx_busy;
    assign ready     = (state == STREAM);
    assign init_fail = (state == FAIL);

    always_comb begin
        state_nxt  = state;
        is_wait    = 1'b0;
        exp_byte   = 8'hFA;
        succ_state = state;
        case (state)
            SEND_RST, SEND_EN: begin
                if (tx_sent) begin
                    if (tx_err)
                        state_nxt = RETRY;
                    else if (tx_done)
                        state_nxt = (state == SEND_RST) ? WAIT_RST_ACK : WAIT_EN_ACK;
                end
            end
            WAIT_RST_ACK: begin
                is_wait    = 1'b1;
                exp_byte   = 8'hFA;
                succ_state = WAIT_BAT;
            end
            WAIT_BAT: begin
                is_wait    = 1'b1;
                exp_byte   = 8'hAA;
                succ_state = WAIT_ID;
            end
            WAIT_ID: begin
                is_wait    = 1'b1;
                exp_byte   = 8'h00;
                succ_state = SEND_EN;
            end
            WAIT_EN_ACK: begin
                is_wait    = 1'b1;
                exp_byte   = 8'hFA;
                succ_state = STREAM;
            end
            RETRY: begin
                state_nxt = (retry_inc == RW'(RETRY_MAX)) ? FAIL : SEND_RST;
            end
            default: ;
        endcase
        if (is_wait) begin
            if (rx_err)
                state_nxt = RETRY;
            else if (rx_valid)
                state_nxt = (rx_data == exp_byte) ? succ_state : RETRY;
            else if (tmo_zero)
                state_nxt = RETRY;
        end
    end

    assign tmo_load = (state_nxt == WAIT_BAT) ? TW'(BAT_CYCLES) : TW'(TIMEOUT_CYCLES);

    // Movement is 9-bit two's complement; an overflow flag zeroes its axis.
    assign dx    = hdr[5] ? 9'd0 : {hdr[3], b1};
    assign dy    = hdr[6] ? 9'd0 : {hdr[4], b2};
    assign x_sum = $signed({{(CW-XW){1'b0}}, x}) + $signed({{(CW-9){dx[8]}}, dx});
    assign y_sum = $signed({{(CW-YW){1'b0}}, y}) - $signed({{(CW-9){dy[8]}}, dy});

    always_comb begin
        x_clamp = x_sum[XW-1:0];
        if (x_sum < 0)
            x_clamp = '0;
        else if (x_sum > X_MAX_S)
            x_clamp = XW'(X_MAX);
        y_clamp = y_sum[YW-1:0];
        if (y_sum < 0)
            y_clamp = '0;
        else if (y_sum > Y_MAX_S)
            y_clamp = YW'(Y_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEND_RST;
            tx_sent   <= 1'b0;
            tx_req    <= 1'b0;
            tx_data   <= 8'h00;
            tmo_cnt   <= TW'(TIMEOUT_CYCLES);
            retry_cnt <= '0;
            hdr       <= '0;
            b1        <= '0;
            b2        <= '0;
            idx       <= '0;
            upd       <= 1'b0;
            x         <= XW'(X_INIT);
            y         <= YW'(Y_INIT);
            buttons   <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_req    <= 1'b0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            upd       <= 1'b0;

            if (state_nxt != state) begin
                tx_sent <= 1'b0;
            end else if (send_go) begin
                tx_sent <= 1'b1;
                tx_req  <= 1'b1;
                tx_data <= (state == SEND_EN) ? 8'hF4 : 8'hFF;
            end

            // down-counter restarts on every state change and on every byte seen in STREAM
            if ((state_nxt != state) || ((state == STREAM) && rx_valid))
                tmo_cnt <= tmo_load;
            else if (!tmo_zero)
                tmo_cnt <= tmo_cnt - TW'(1);

            if (state == RETRY)
                retry_cnt <= retry_inc;
            else if ((state == WAIT_EN_ACK) && (state_nxt == STREAM))
                retry_cnt <= '0;

            if (state != STREAM) begin
                idx <= '0;
            end else begin
                if (rx_err) begin
                    sync_err <= 1'b1;
                    idx      <= '0;
                end else if (rx_valid) begin
                    case (idx)
                        2'd0: begin
                            if (rx_data[3]) begin
                                hdr <= {rx_data[7:4], rx_data[2:0]};
                                idx <= 2'd1;
                            end else begin
                                sync_err <= 1'b1;
                            end
                        end
                        2'd1: begin
                            b1  <= rx_data;
                            idx <= 2'd2;
                        end
                        default: begin
                            b2  <= rx_data;
                            idx <= 2'd0;
                            upd <= 1'b1;
                        end
                    endcase
                end else if ((idx != 2'd0) && tmo_zero) begin
                    sync_err <= 1'b1;
                    idx      <= '0;
                end

                if (upd) begin
                    x         <= x_clamp;
                    y         <= y_clamp;
                    buttons   <= hdr[2:0];
                    pkt_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Self-checking bench for ps2_mouse_ctrl: scripted mouse replies plus random
// packets compared against an arithmetic cursor model.
module tb_ps2_mouse_ctrl;

    localparam int TMO   = 200;
    localparam int BAT   = 1000;
    localparam int RMAX  = 3;
    localparam int XMAX  = 639;
    localparam int YMAX  = 479;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_err = 1'b0;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_err = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] buttons;
    logic       pkt_valid;
    logic       ready;
    logic       init_fail;
    logic       sync_err;

    always #5 clk = ~clk;

    ps2_mouse_ctrl #(
        .TIMEOUT_CYCLES(TMO), .BAT_CYCLES(BAT), .RETRY_MAX(RMAX),
        .XW(10), .YW(10), .X_MAX(XMAX), .Y_MAX(YMAX), .X_INIT(320), .Y_INIT(240)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err),
        .x(x), .y(y), .buttons(buttons), .pkt_valid(pkt_valid),
        .ready(ready), .init_fail(init_fail), .sync_err(sync_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int tx_cnt = 0;
    int pkt_cnt = 0;
    int serr_cnt = 0;
    int mx, my, mbtn;

    always @(negedge clk) begin
        if (tx_req === 1'b1)    tx_cnt++;
        if (pkt_valid === 1'b1) pkt_cnt++;
        if (sync_err === 1'b1)  serr_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Cursor model: signed 9-bit deltas, overflow zeroes the axis, y grows downward.
    task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dxm, dym;
        dxm = b0[6] ? 0 : (int'(b1) - (b0[4] ? 256 : 0));
        dym = b0[7] ? 0 : (int'(b2) - (b0[5] ? 256 : 0));
        mx   = clampi(mx + dxm, XMAX);
        my   = clampi(my - dym, YMAX);
        mbtn = int'(b0[2:0]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_rx_err();
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
    endtask

    task automatic serve_tx(input string tag, input logic [7:0] exp);
        int k = 0;
        while (tx_req !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_req"}, int'(tx_req), 1);
        if (tx_req === 1'b1) begin
            check({tag, "_data"}, int'(tx_data), int'(exp));
            tx_busy = 1'b1;
            tick(3);
            tx_busy = 1'b0;
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, int'(x), mx);
        check({tag, "_y"}, int'(y), my);
        check({tag, "_btn"}, int'(buttons), mbtn);
    endtask

    task automatic send_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        int p0 = pkt_cnt;
        send_rx(b0);
        tick($urandom_range(0, 4));
        send_rx(b1);
        tick($urandom_range(0, 4));
        send_rx(b2);
        model_pkt(b0, b1, b2);
        tick(4);
        check({tag, "_pv"}, pkt_cnt - p0, 1);
        check_pos(tag);
    endtask

    task automatic do_init();
        serve_tx("rst_cmd", 8'hFF);
        send_rx(8'hFA);
        tick($urandom_range(0, 5));
        send_rx(8'hAA);
        tick($urandom_range(0, 5));
        send_rx(8'h00);
        serve_tx("en_cmd", 8'hF4);
        send_rx(8'hFA);
        tick(2);
    endtask

    initial begin
        int t0, s0, p0;
        logic [7:0] r0, r1, r2;
        tick(3);
        check("rst_x", int'(x), 320);
        check("rst_y", int'(y), 240);
        check("rst_btn", int'(buttons), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_fail", int'(init_fail), 0);
        check("rst_txreq", int'(tx_req), 0);
        check("rst_strobes", int'({pkt_valid, sync_err}), 0);

        rst = 1'b0;
        t0  = tx_cnt;
        do_init();
        check("init_ready", int'(ready), 1);
        check("init_tx_count", tx_cnt - t0, 2);
        mx = 320; my = 240; mbtn = 0;
        check_pos("init");

        send_pkt("pos_move", 8'h09, 8'h05, 8'h03);
        for (int i = 0; i < 4; i++) send_pkt("to_corner", 8'h38, 8'h80, 8'h80);
        send_pkt("near_corner", 8'h08, 8'h02, 8'h01);
        check("near_corner_abs", int'(x) * 1000 + int'(y), 2 * 1000 + 478);
        send_pkt("neg_clamp", 8'h38, 8'hFB, 8'hFE);

        s0 = serr_cnt; p0 = pkt_cnt;
        send_rx(8'h05);
        tick(3);
        check("nosync_serr", serr_cnt - s0, 1);
        check("nosync_pv", pkt_cnt - p0, 0);
        send_pkt("x_ovf", 8'h48, 8'h10, 8'h10);

        for (int i = 0; i < 40; i++) begin
            r0 = 8'($urandom()) | 8'h08;
            r1 = 8'($urandom());
            r2 = 8'($urandom());
            send_pkt("rand", r0, r1, r2);
        end

        s0 = serr_cnt; p0 = pkt_cnt;
        send_rx(8'h08);
        tick(TMO + 20);
        check("gap_serr", serr_cnt - s0, 1);
        check("gap_pv", pkt_cnt - p0, 0);
        send_pkt("after_gap", 8'h08, 8'h01, 8'h00);

        s0 = serr_cnt;
        send_rx(8'h08);
        send_rx(8'h01);
        pulse_rx_err();
        tick(2);
        check("rxerr_serr", serr_cnt - s0, 1);
        send_pkt("after_rxerr", 8'h19, 8'hF0, 8'h07);

        // Back-to-back packets: the next header lands in the update cycle.
        p0 = pkt_cnt;
        send_rx(8'h0A); send_rx(8'h07); send_rx(8'h03);
        send_rx(8'h2C); send_rx(8'h04); send_rx(8'hFD);
        model_pkt(8'h0A, 8'h07, 8'h03);
        model_pkt(8'h2C, 8'h04, 8'hFD);
        tick(4);
        check("b2b_pv", pkt_cnt - p0, 2);
        check_pos("b2b");

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        t0 = tx_cnt;
        for (int i = 0; i < RMAX; i++) begin
            serve_tx("fail_rst_cmd", 8'hFF);
            send_rx(8'hFE);
        end
        tick(10);
        check("fail_flag", int'(init_fail), 1);
        check("fail_ready", int'(ready), 0);
        send_rx(8'hFA);
        tick(300);
        check("fail_tx_count", tx_cnt - t0, RMAX);
        check("fail_sticky", int'(init_fail), 1);

        rst = 1'b1;
        tick(2);
        check("rerst_fail", int'(init_fail), 0);
        rst = 1'b0;
        serve_tx("rerst_cmd", 8'hFF);
        send_rx(8'hFA);
        send_rx(8'hAA);
        serve_tx("id_timeout_retry", 8'hFF);
        do_init();
        check("rerst_ready", int'(ready), 1);
        mx = 320; my = 240; mbtn = 0;
        check_pos("rerst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ps2_mouse_ctrl.md
Name: ps2_mouse_ctrl

Overview:
Host-side sequencer for the PS/2 mouse, sitting between the PS/2 byte receiver/transmitter pair and the CPU-visible mouse registers. After reset it initialises the mouse with 0xFF (reset) and then 0xF4 (enable reporting), checking every response. It then assembles 3-byte stream packets into an absolute cursor position clamped to the screen, plus button state. Timeouts and retries cover a silent or desynchronised device.

Parameters:
TIMEOUT_CYCLES, 100000, max clk cycles to wait for an ACK/ID byte, and max gap between bytes of one packet
BAT_CYCLES, 50000000, max clk cycles to wait for BAT result 0xAA after the reset ACK
RETRY_MAX, 3, init attempts before entering FAIL
XW, 10, x position width
YW, 10, y position width
X_MAX, 639, max x value
Y_MAX, 479, max y value
X_INIT, 320, x value at reset
Y_INIT, 240, y value at reset

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx_valid  in  1  1-cycle strobe: rx_data holds a good received byte
rx_data  in  8  received byte
rx_err  in  1  1-cycle strobe: frame/parity error on receive
tx_req  out  1  1-cycle request to send tx_data
tx_data  out  8  command byte
tx_busy  in  1  transmitter busy
tx_done  in  1  1-cycle strobe: byte sent and line released
tx_err  in  1  1-cycle strobe: transmit failed
x  out  XW  cursor x
y  out  YW  cursor y
buttons  out  3  {middle, right, left}
pkt_valid  out  1  1-cycle strobe: x/y/buttons updated
ready  out  1  1 while in STREAM
init_fail  out  1  1 while in FAIL
sync_err  out  1  1-cycle strobe: byte discarded for sync/timeout/rx_err

Behaviour:
Reset (async, active-high):
- x=X_INIT, y=Y_INIT, buttons=0; tx_req, pkt_valid, ready, init_fail, sync_err all 0; retry count 0; state SEND_RST.
- Reset mid-operation aborts everything and restarts init.

FSM:
- SEND_RST: when !tx_busy, pulse tx_req with tx_data=0xFF, then wait tx_done -> WAIT_RST_ACK. tx_err -> RETRY.
- WAIT_RST_ACK: 0xFA -> WAIT_BAT. Any other byte, rx_err, or TIMEOUT_CYCLES elapsed -> RETRY.
- WAIT_BAT: 0xAA -> WAIT_ID. Other byte, rx_err, or BAT_CYCLES elapsed -> RETRY.
- WAIT_ID: 0x00 -> SEND_EN. Other byte, rx_err, or timeout -> RETRY.
- SEND_EN: same as SEND_RST but sends 0xF4; next state WAIT_EN_ACK.
- WAIT_EN_ACK: 0xFA -> STREAM, with packet index 0 and retry count cleared. Other byte, rx_err, or timeout -> RETRY.
- RETRY (1 cycle): retry+1; if the new count equals RETRY_MAX -> FAIL, else -> SEND_RST.
- FAIL: terminal until reset; init_fail=1; all rx bytes ignored.
- STREAM: ready=1; never issues tx_req.

Timeout counter:
- Clears on state entry and on every accepted byte.
- Wait timeouts count from tx_done.

Packet assembly (STREAM):
- Index 0: byte kept as b0 only if bit3=1, else discarded with a sync_err pulse and index stays 0.
- Index 1 stores b1; index 2 stores b2.
- rx_err at any index: sync_err pulse, index -> 0, partial packet dropped.
- Gap > TIMEOUT_CYCLES with index 1 or 2: sync_err pulse, index -> 0. No timeout action at index 0.

Packet update (cycle after b2 arrives):
- dx = 9-bit two's complement {b0[4], b1}; dy = {b0[5], b2}.
- If b0[6] is set, dx is forced to 0; if b0[7] is set, dy is forced to 0.
- x_new = x + dx; y_new = y - dy (screen y grows downward).
- Compute in signed width max(XW,YW)+2, then clamp to [0, X_MAX] / [0, Y_MAX].
- buttons = b0[2:0]; pkt_valid pulses 1 cycle together with the register update; index -> 0.
- A byte arriving in the same cycle as the update is treated as index 0.

Test Plan:
- Init: reset; reply 0xFA, 0xAA, 0x00 to tx 0xFF; reply 0xFA to tx 0xF4 -> exactly two tx_req pulses (0xFF then 0xF4); ready=1; x=320, y=240.
- Positive move: in STREAM send 0x09, 0x05, 0x03 -> pkt_valid once; x=325, y=237, buttons=3'b001.
- Negative + clamp: from x=2, y=478 send 0x38, 0xFB, 0xFE -> x=0 (clamped from -3), y=479 (clamped from 480), buttons=0.
- Overflow/sync: send 0x05 -> sync_err, no update. Then 0x48, 0x10, 0x10 -> x unchanged (X overflow), y decreased by 16.
- Packet timeout: send 0x08, then idle TIMEOUT_CYCLES+1 -> sync_err. Then 0x08, 0x01, 0x00 -> x+1 (the late byte started a new packet).
- Init failure: reply 0xFE to every 0xFF, RETRY_MAX=3 -> three 0xFF sends, then init_fail=1 and no further tx_req. Assert rst -> init restarts with 0xFF.
